// File: rtl/bitonic_pkg.sv
// Shared types and helpers for the bitonic sort sequencer and its routing logic.
package bitonic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ADV,
        OUT
    } state_e;

    // Stage/step counter width; s and j both range 0..LOG_N-1.
    localparam int unsigned LOG_N_DFLT = 3;
    localparam int unsigned CNT_W_DFLT = (LOG_N_DFLT > 1) ? $clog2(LOG_N_DFLT) : 1;

    function automatic int unsigned cnt_width(input int unsigned log_n);
        return (log_n > 1) ? $clog2(log_n) : 1;
    endfunction

    // Lower index of comparator k's pair at step j: k with a 0 bit inserted at position j.
    function automatic int unsigned pair_lo(input int unsigned k, input int unsigned j);
        int unsigned mask;
        mask = (32'd1 << j) - 32'd1;
        return ((k & ~mask) << 1) | (k & mask);
    endfunction

    // Passes in a full sort: one per (stage, step) combination.
    function automatic int unsigned num_passes(input int unsigned log_n);
        return (log_n * (log_n + 1)) / 2;
    endfunction

endpackage

// File: rtl/bitonic_route.sv
// Combinational gather of element pairs into node slots and scatter of node results back.
module bitonic_route
    import bitonic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LOG_N      = 3,
    parameter int unsigned CNT_W      = 2
) (
    input  logic [(1 << LOG_N)*DATA_WIDTH-1:0] i_gather_src,
    input  logic [CNT_W-1:0]                   i_gather_j,
    output logic [(1 << LOG_N)*DATA_WIDTH-1:0] o_node_din,
    input  logic [(1 << LOG_N)*DATA_WIDTH-1:0] i_work,
    input  logic [(1 << LOG_N)*DATA_WIDTH-1:0] i_node_dout,
    input  logic [CNT_W-1:0]                   i_s,
    input  logic [CNT_W-1:0]                   i_j,
    output logic [(1 << LOG_N)*DATA_WIDTH-1:0] o_work_next
);

    localparam int unsigned HALF = (1 << LOG_N) / 2;

    // Gather: A of comparator k from W[lo], B from W[lo + 2**j].
    always_comb begin
        o_node_din = '0;
        for (int unsigned jj = 0; jj < LOG_N; jj++) begin
            if (i_gather_j == CNT_W'(jj)) begin
                for (int unsigned k = 0; k < HALF; k++) begin
                    o_node_din[k*DATA_WIDTH +: DATA_WIDTH] =
                        i_gather_src[pair_lo(k, jj)*DATA_WIDTH +: DATA_WIDTH];
                    o_node_din[(k+HALF)*DATA_WIDTH +: DATA_WIDTH] =
                        i_gather_src[(pair_lo(k, jj) + (32'd1 << jj))*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Scatter: bit (s+1) of lo picks ascending (L low, H high) or descending placement.
    always_comb begin
        logic [DATA_WIDTH-1:0] v_h;
        logic [DATA_WIDTH-1:0] v_l;
        int unsigned           v_lo;
        int unsigned           v_hi;
        logic                  v_desc;
        v_h         = '0;
        v_l         = '0;
        v_lo        = 0;
        v_hi        = 0;
        v_desc      = 1'b0;
        o_work_next = i_work;
        for (int unsigned jj = 0; jj < LOG_N; jj++) begin
            if (i_j == CNT_W'(jj)) begin
                for (int unsigned k = 0; k < HALF; k++) begin
                    v_lo   = pair_lo(k, jj);
                    v_hi   = v_lo + (32'd1 << jj);
                    v_h    = i_node_dout[k*DATA_WIDTH +: DATA_WIDTH];
                    v_l    = i_node_dout[(k+HALF)*DATA_WIDTH +: DATA_WIDTH];
                    v_desc = ((v_lo >> (32'(i_s) + 32'd1)) & 32'd1) != 32'd0;
                    o_work_next[v_lo*DATA_WIDTH +: DATA_WIDTH] = v_desc ? v_h : v_l;
                    o_work_next[v_hi*DATA_WIDTH +: DATA_WIDTH] = v_desc ? v_l : v_h;
                end
            end
        end
    end

endmodule

// File: rtl/bitonic_sort_ctrl.sv
// Bitonic sort sequencer driving one shared compare node, one pass at a time.
// Optional macro BITONIC_WDOG_EN adds a sticky err output and a node_done watchdog.
module bitonic_sort_ctrl
    import bitonic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned LOG_N       = 3,
    parameter int unsigned WDOG_CYCLES = 64
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [(1 << LOG_N)*DATA_WIDTH-1:0]  in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [(1 << LOG_N)*DATA_WIDTH-1:0]  out_data,
    output logic                                node_valid,
    output logic [(1 << LOG_N)*DATA_WIDTH-1:0]  node_din,
    input  logic                                node_done,
    input  logic [(1 << LOG_N)*DATA_WIDTH-1:0]  node_dout,
    output logic                                busy
`ifdef BITONIC_WDOG_EN
    ,
    output logic                                err
`endif
);

    localparam int unsigned VW    = (1 << LOG_N) * DATA_WIDTH;
    localparam int unsigned CNT_W = cnt_width(LOG_N);

    state_e           r_state;
    logic [CNT_W-1:0] r_s;
    logic [CNT_W-1:0] r_j;
    logic [VW-1:0]    r_work;
    logic [VW-1:0]    r_node_din;
    logic             r_node_valid;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [CNT_W-1:0] w_j_next;
    logic [VW-1:0]    w_gather_src;
    logic [VW-1:0]    w_gather;
    logic [VW-1:0]    w_scatter;

`ifdef BITONIC_WDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);
    logic [WDOG_W-1:0] r_wdog;
    logic              r_err;
    assign err = r_err;
`else
    logic w_unused_wdog;
    assign w_unused_wdog = ^32'(WDOG_CYCLES);
`endif

    // Step index of the pass about to be issued, and the vector it gathers from.
    always_comb begin
        w_j_next     = '0;
        w_gather_src = r_work;
        if (r_state == IDLE) begin
            w_gather_src = in_data;
        end else if (r_j != '0) begin
            w_j_next = r_j - CNT_W'(1);
        end else begin
            w_j_next = r_s + CNT_W'(1);
        end
    end

    bitonic_route #(
        .DATA_WIDTH (DATA_WIDTH),
        .LOG_N      (LOG_N),
        .CNT_W      (CNT_W)
    ) u_route (
        .i_gather_src (w_gather_src),
        .i_gather_j   (w_j_next),
        .o_node_din   (w_gather),
        .i_work       (r_work),
        .i_node_dout  (node_dout),
        .i_s          (r_s),
        .i_j          (r_j),
        .o_work_next  (w_scatter)
    );

    // Sequencer: load, issue/wait/advance per pass, then hold the result for the sink.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_s          <= '0;
            r_j          <= '0;
            r_work       <= '0;
            r_node_din   <= '0;
            r_node_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
`ifdef BITONIC_WDOG_EN
            r_wdog       <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
            r_node_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_work       <= in_data;
                        r_s          <= '0;
                        r_j          <= '0;
                        r_node_din   <= w_gather;
                        r_node_valid <= 1'b1;
                        r_in_ready   <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef BITONIC_WDOG_EN
                    r_wdog  <= '0;
`endif
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (node_done) begin
                        r_work  <= w_scatter;
                        r_state <= ADV;
                    end
`ifdef BITONIC_WDOG_EN
                    else if (r_wdog == WDOG_W'(WDOG_CYCLES - 1)) begin
                        r_err      <= 1'b1;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= IDLE;
                    end else begin
                        r_wdog <= r_wdog + WDOG_W'(1);
                    end
`endif
                end
                ADV: begin
                    if (r_j != '0) begin
                        r_j          <= r_j - CNT_W'(1);
                        r_node_din   <= w_gather;
                        r_node_valid <= 1'b1;
                        r_state      <= ISSUE;
                    end else if (r_s < CNT_W'(LOG_N - 1)) begin
                        r_s          <= r_s + CNT_W'(1);
                        r_j          <= r_s + CNT_W'(1);
                        r_node_din   <= w_gather;
                        r_node_valid <= 1'b1;
                        r_state      <= ISSUE;
                    end else begin
                        r_out_valid <= 1'b1;
                        r_state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_work;
    assign node_valid = r_node_valid;
    assign node_din   = r_node_din;
    assign busy       = r_busy;

endmodule

// File: tb/tb_bitonic_sort_ctrl.sv
// Directed bench for bitonic_sort_ctrl with a fixed-latency compare node model.
module tb_bitonic_sort_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned LN = 3;
    localparam int          NODE_LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        node_valid;
    logic [63:0] node_din;
    logic        node_done = 1'b0;
    logic [63:0] node_dout = '0;
    logic        busy;
`ifdef BITONIC_WDOG_EN
    logic        err;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_pulses = 0;
    int lat_cnt  = 0;
    bit node_mute = 1'b0;

    bitonic_sort_ctrl #(
        .DATA_WIDTH  (DW),
        .LOG_N       (LN),
        .WDOG_CYCLES (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .node_valid (node_valid),
        .node_din   (node_din),
        .node_done  (node_done),
        .node_dout  (node_dout),
        .busy       (busy)
`ifdef BITONIC_WDOG_EN
        ,
        .err        (err)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pk(input logic [7:0] e0, input logic [7:0] e1,
                                       input logic [7:0] e2, input logic [7:0] e3,
                                       input logic [7:0] e4, input logic [7:0] e5,
                                       input logic [7:0] e6, input logic [7:0] e7);
        return {e7, e6, e5, e4, e3, e2, e1, e0};
    endfunction

    // Four comparators: slot k gets max(A,B), slot k+4 gets min(A,B).
    function automatic logic [63:0] node_fn(input logic [63:0] din);
        logic [63:0] r;
        logic [7:0]  a;
        logic [7:0]  b;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            a = din[k*8 +: 8];
            b = din[(k+4)*8 +: 8];
            r[k*8 +: 8]     = (a > b) ? a : b;
            r[(k+4)*8 +: 8] = (a > b) ? b : a;
        end
        return r;
    endfunction

    // Node model: node_done visible NODE_LAT cycles after the node_valid cycle.
    always @(posedge clk) begin
        node_done <= 1'b0;
        if (node_valid) begin
            n_pulses  <= n_pulses + 1;
            node_dout <= node_fn(node_din);
            lat_cnt   <= NODE_LAT - 1;
        end else if (lat_cnt == 1) begin
            node_done <= !node_mute;
            lat_cnt   <= 0;
        end else if (lat_cnt != 0) begin
            lat_cnt <= lat_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Present v at a negedge in IDLE, handshake, and return at the negedge where out_valid is seen.
    task automatic send_and_sort(input string tag, input logic [63:0] v, input logic [63:0] exp);
        int cyc;
        int base;
        bit got;
        in_data  = v;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        base = n_pulses;
        @(posedge clk);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            in_valid = 1'b0;
            cyc++;
            if (cyc == 1) check({tag, "_busy"}, 64'(busy), 64'd1);
            if (out_valid) got = 1'b1;
        end
        check({tag, "_latency"}, 64'(cyc), 64'd31);
        check({tag, "_passes"}, 64'(n_pulses - base), 64'd6);
        check({tag, "_data"}, out_data, exp);
    endtask

    initial begin
        logic [63:0] exp1;
        int          cyc;
        exp1 = pk(8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7);

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_node_valid", 64'(node_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_node_din", node_din, 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Reverse-ordered vector, then stall the sink for 10 cycles
        out_ready = 1'b0;
        send_and_sort("rev", pk(8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0), exp1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d_out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("stall%0d_out_data", i), out_data, exp1);
            check($sformatf("stall%0d_in_ready", i), 64'(in_ready), 64'd0);
            check($sformatf("stall%0d_node_valid", i), 64'(node_valid), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("post_out_valid", 64'(out_valid), 64'd0);
        check("post_in_ready", 64'(in_ready), 64'd1);
        check("post_busy", 64'(busy), 64'd0);

        // Duplicates and extremes, then a back-to-back vector
        send_and_sort("dup", pk(8'd200, 8'd3, 8'd3, 8'd255, 8'd0, 8'd17, 8'd128, 8'd3),
                      pk(8'd0, 8'd3, 8'd3, 8'd3, 8'd17, 8'd128, 8'd200, 8'd255));
        in_data  = pk(8'd10, 8'd90, 8'd20, 8'd80, 8'd30, 8'd70, 8'd40, 8'd60);
        in_valid = 1'b1;
        @(negedge clk);
        send_and_sort("b2b", pk(8'd10, 8'd90, 8'd20, 8'd80, 8'd30, 8'd70, 8'd40, 8'd60),
                      pk(8'd10, 8'd20, 8'd30, 8'd40, 8'd60, 8'd70, 8'd80, 8'd90));
        @(negedge clk);

        // Async reset during the third WAIT
        in_data  = pk(8'd1, 8'd0, 8'd3, 8'd2, 8'd5, 8'd4, 8'd7, 8'd6);
        in_valid = 1'b1;
        begin
            int base;
            base = n_pulses;
            @(posedge clk);
            cyc = 0;
            while ((n_pulses - base) < 3 && cyc < 100) begin
                @(negedge clk);
                in_valid = 1'b0;
                cyc++;
            end
        end
        check("mid_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_node_valid", 64'(node_valid), 64'd0);
        check("arst_out_data", out_data, 64'd0);
        check("arst_node_din", node_din, 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("after_rst_out_valid", 64'(out_valid), 64'd0);
        send_and_sort("fresh", pk(8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2),
                      pk(8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9));
        @(negedge clk);

`ifdef BITONIC_WDOG_EN
        // Node never answers: watchdog abandons the vector
        check("wdog_err_before", 64'(err), 64'd0);
        node_mute = 1'b1;
        in_data   = pk(8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd9, 8'd8);
        in_valid  = 1'b1;
        @(posedge clk);
        cyc = 0;
        while (!err && cyc < 100) begin
            @(negedge clk);
            in_valid = 1'b0;
            cyc++;
            if (out_valid) check("wdog_no_out", 64'(out_valid), 64'd0);
        end
        check("wdog_cycles", 64'(cyc), 64'd18);
        check("wdog_err", 64'(err), 64'd1);
        check("wdog_busy", 64'(busy), 64'd0);
        check("wdog_in_ready", 64'(in_ready), 64'd1);
        check("wdog_out_valid", 64'(out_valid), 64'd0);
        node_mute = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bitonic_sort_ctrl.md
Name: bitonic_sort_ctrl

Overview:
- Sequencer that runs a full N-element bitonic sort (N = 2**LOG_N) on one shared bitonic_node instance with NODE_ORDER = LOG_N.
- Each pass it gathers element pairs from a working register into the node's A/B slots and issues the node.
- It then scatters the node's H/L results back into the working register, applying the per-pair direction.
- Sits between an upstream valid/ready vector source and a downstream valid/ready sink. Unsorted vector in, ascending-sorted vector out.

Parameters:
- DATA_WIDTH, 8, width of one element.
- LOG_N, 3, log2 of element count; N = 2**LOG_N, node has N/2 comparators.
- WDOG_CYCLES, 64, node_done timeout in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream vector valid.
- in_ready  out  1  controller can accept a vector.
- in_data  in  N*DATA_WIDTH  element i at [DATA_WIDTH*(i+1)-1 -: DATA_WIDTH].
- out_valid  out  1  sorted vector valid.
- out_ready  in  1  downstream accepts.
- out_data  out  N*DATA_WIDTH  sorted vector; element 0 is the smallest.
- node_valid  out  1  issue pulse to the node.
- node_din  out  N*DATA_WIDTH  to node data_in; slot k = A of comparator k, slot k+N/2 = B.
- node_done  in  1  node result valid.
- node_dout  in  N*DATA_WIDTH  from node data_out; slot k = H, slot k+N/2 = L; H >= L unsigned.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, async): state = IDLE, stage counters = 0, working register = 0, in_ready = 1, out_valid = 0, node_valid = 0, busy = 0. Reset asserted mid-sort abandons the vector; nothing is emitted.
- IDLE:
  - in_ready = 1.
  - in_valid & in_ready loads in_data into the working register, sets s = 0, j = 0, and moves to ISSUE.
- ISSUE:
  - node_valid = 1 for exactly one cycle; node_din is registered and held stable until node_done.
  - Pair k uses d = 2**j and lo = k with a 0 bit inserted at bit position j; A = W[lo], B = W[lo+d].
  - Next state WAIT.
- WAIT:
  - Holds until node_done = 1; node latency is unbounded.
  - On node_done, per pair: if bit (s+1) of lo = 0 (ascending), W[lo] <= L and W[lo+d] <= H; otherwise W[lo] <= H and W[lo+d] <= L.
  - Next state ADV.
- ADV:
  - If j > 0: j <= j-1, go to ISSUE.
  - Else if s < LOG_N-1: s <= s+1, j <= s+1, go to ISSUE.
  - Else go to OUT.
  - Total passes = LOG_N*(LOG_N+1)/2 (6 for N=8).
- OUT:
  - out_valid = 1 and out_data = W, both held stable until out_ready.
  - On out_valid & out_ready, go to IDLE.
  - No bypass: in_ready is 0 in OUT, so a new vector is accepted one cycle after the handshake at the earliest.
- Latency per vector, with node latency Ln measured from node_valid to node_done:
  - 1 load cycle, plus passes*(Ln+2), plus the OUT cycle(s).
- node_done while not in WAIT is ignored.
- Comparison is unsigned; equal elements are stable only in value, not in position.

Optional Feature:
- Macro: BITONIC_WDOG_EN.
- When defined:
  - Adds output err (1 bit, reset 0, sticky until reset).
  - A counter counts cycles in WAIT; reaching WDOG_CYCLES without node_done sets err, drops the vector, and returns to IDLE.
  - node_done in the same cycle as the timeout wins; err is not set.
- When undefined: no err port, no counter; WAIT waits indefinitely.

Decomposition:
- Shared package bitonic_pkg:
  - state enum {IDLE, ISSUE, WAIT, ADV, OUT}.
  - Function pair_lo(k, j).
  - Function num_passes(LOG_N).
  - Counter width localparam $clog2(LOG_N).
- One natural sub-module: bitonic_route.
  - Purely combinational gather (W, j -> node_din) and scatter (node_dout, W, s, j -> W_next).
  - The FSM and registers stay in bitonic_sort_ctrl.

Test Plan (N=8, DATA_WIDTH=8, node model with Ln=3):
- Load in_data elements 0..7 = {7,6,5,4,3,2,1,0}:
  - exactly 6 node_valid pulses occur.
  - out_data elements 0..7 = {0,1,2,3,4,5,6,7}.
  - first out_valid appears 1 + 6*5 = 31 cycles after the input handshake.
- Load {200,3,3,255,0,17,128,3}: out = {0,3,3,3,17,128,200,255}.
- Hold out_ready = 0 for 10 cycles in OUT: out_valid and out_data are stable throughout, in_ready = 0, no node_valid is issued.
- Drop reset to 0 during the 3rd WAIT: all outputs return to reset values immediately, with no clock edge needed. After release, a fresh vector sorts correctly.
- Back-to-back vectors with out_ready = 1: the second is accepted on the cycle after the first out handshake.
- With BITONIC_WDOG_EN and WDOG_CYCLES = 16, the node withholds done: err rises 16 cycles into WAIT, state returns to IDLE, out_valid never asserts.
